fft_addr_gen: RTL and testbench

// - Sequencer for an in-place radix-2 DIT FFT. Sits directly upstream of butterfly_unit and its data RAM.
// - Per stage, issues read-address pairs (a,b) to a synchronous dual-port data RAM and a twiddle ROM index.
// - Issues the matching write-back addresses and write enable, delayed to line up with butterfly_unit output.
// - Data is bit-reversed in RAM before start; results are in natural order when the run finishes.

---
 rtl/fft_addr_gen.sv | 205 ++++++++++++++++++++
 tb/tb_fft_addr_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_gen.sv
// Address sequencer for an in-place radix-2 DIT FFT: read pairs, twiddle index and delayed write-back.
// Optional feature macro: FFT_ABORT_EN adds i_abort to cut a run short without an o_done pulse.
module fft_addr_gen #(
    parameter int LOG2N    = 4,
    parameter int BFLY_LAT = 2,
    parameter int RD_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
`ifdef FFT_ABORT_EN
    input  logic             i_abort,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_stage,
    output logic             o_rd_en,
    output logic [LOG2N-1:0] o_rd_addr_a,
    output logic [LOG2N-1:0] o_rd_addr_b,
    output logic [LOG2N-2:0] o_tw_addr,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr_a,
    output logic [LOG2N-1:0] o_wr_addr_b
);

    localparam int D   = RD_LAT + BFLY_LAT;
    localparam int K_W = LOG2N - 1;
    localparam int C_W = (D > 1) ? $clog2(D) : 1;

    localparam logic [C_W-1:0] CNT_LAST = C_W'(D - 1);
    localparam logic [K_W-1:0] K_LAST   = {K_W{1'b1}};
    localparam logic [3:0]     S_LAST   = 4'(LOG2N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [3:0]       s_q;
    logic [K_W-1:0]   k_q;
    logic [C_W-1:0]   cnt_q;
    logic             armed_q;
    logic             abort_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_en_q;
    logic [LOG2N-1:0] rd_a_q;
    logic [LOG2N-1:0] rd_b_q;
    logic [K_W-1:0]   tw_q;

    logic             wv_q [D];
    logic [LOG2N-1:0] wa_q [D];
    logic [LOG2N-1:0] wb_q [D];

    logic             abort_s;
    logic [K_W-1:0]   k_nxt_s;
    logic [3:0]       s_nxt_s;

    function automatic logic [LOG2N-1:0] calc_addr_a(input logic [3:0] s, input logic [K_W-1:0] k);
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] mask;
        kx          = {1'b0, k};
        mask        = (LOG2N'(1) << s) - LOG2N'(1);
        calc_addr_a = ((kx >> s) << (s + 4'd1)) | (kx & mask);
    endfunction

    function automatic logic [LOG2N-1:0] calc_addr_b(input logic [3:0] s, input logic [K_W-1:0] k);
        calc_addr_b = calc_addr_a(s, k) + (LOG2N'(1) << s);
    endfunction

    // In the last stage 1<<s overflows K_W bits to zero, so the mask becomes all ones as required.
    function automatic logic [K_W-1:0] calc_tw(input logic [3:0] s, input logic [K_W-1:0] k);
        logic [K_W-1:0] mask;
        mask    = (K_W'(1) << s) - K_W'(1);
        calc_tw = (k & mask) << (S_LAST - s);
    endfunction

`ifdef FFT_ABORT_EN
    assign abort_s = i_abort;
`else
    assign abort_s = 1'b0;
`endif

    assign k_nxt_s = k_q + K_W'(1);
    assign s_nxt_s = s_q + 4'd1;

    // Sequencer FSM; all outputs registered. armed_q blocks a start on the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            k_q     <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && armed_q) begin
                        state_q <= RUN;
                        s_q     <= 4'd0;
                        k_q     <= '0;
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        rd_a_q  <= calc_addr_a(4'd0, '0);
                        rd_b_q  <= calc_addr_b(4'd0, '0);
                        tw_q    <= calc_tw(4'd0, '0);
                    end else begin
                        busy_q  <= 1'b0;
                        rd_en_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_s || (k_q == K_LAST)) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                        rd_en_q <= 1'b0;
                        abort_q <= abort_q | abort_s;
                    end else begin
                        k_q     <= k_nxt_s;
                        rd_en_q <= 1'b1;
                        rd_a_q  <= calc_addr_a(s_q, k_nxt_s);
                        rd_b_q  <= calc_addr_b(s_q, k_nxt_s);
                        tw_q    <= calc_tw(s_q, k_nxt_s);
                    end
                end
                DRAIN: begin
                    if (cnt_q == CNT_LAST) begin
                        if (abort_q || abort_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (s_q != S_LAST) begin
                            state_q <= RUN;
                            s_q     <= s_nxt_s;
                            k_q     <= '0;
                            rd_en_q <= 1'b1;
                            rd_a_q  <= calc_addr_a(s_nxt_s, '0);
                            rd_b_q  <= calc_addr_b(s_nxt_s, '0);
                            tw_q    <= calc_tw(s_nxt_s, '0);
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= cnt_q + C_W'(1);
                        abort_q <= abort_q | abort_s;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Write-back delay line: stage D-1 holds the read issued D cycles earlier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < D; i++) begin
                wv_q[i] <= 1'b0;
                wa_q[i] <= '0;
                wb_q[i] <= '0;
            end
        end else begin
            wv_q[0] <= rd_en_q;
            wa_q[0] <= rd_a_q;
            wb_q[0] <= rd_b_q;
            for (int i = 1; i < D; i++) begin
                wv_q[i] <= wv_q[i-1];
                wa_q[i] <= wa_q[i-1];
                wb_q[i] <= wb_q[i-1];
            end
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_stage     = s_q;
    assign o_rd_en     = rd_en_q;
    assign o_rd_addr_a = rd_a_q;
    assign o_rd_addr_b = rd_b_q;
    assign o_tw_addr   = tw_q;
    assign o_wr_en     = wv_q[D-1];
    assign o_wr_addr_a = wa_q[D-1];
    assign o_wr_addr_b = wb_q[D-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen at LOG2N=3, D=3; expected per-cycle outputs are queued at start and popped each cycle.
module tb_fft_addr_gen;

    localparam int LOG2N = 3;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_abort;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_stage;
    logic       o_rd_en;
    logic [2:0] o_rd_addr_a;
    logic [2:0] o_rd_addr_b;
    logic [1:0] o_tw_addr;
    logic       o_wr_en;
    logic [2:0] o_wr_addr_a;
    logic [2:0] o_wr_addr_b;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [1:0] tw;
        logic       wr_en;
        logic [2:0] wa;
        logic [2:0] wb;
        logic [3:0] stage;
    } exp_t;

    exp_t exp_q[$];

    int pa_tab [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int pb_tab [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int tw_tab [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    fft_addr_gen #(.LOG2N(LOG2N), .BFLY_LAT(2), .RD_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
`ifdef FFT_ABORT_EN
        .i_abort     (i_abort),
`endif
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_stage     (o_stage),
        .o_rd_en     (o_rd_en),
        .o_rd_addr_a (o_rd_addr_a),
        .o_rd_addr_b (o_rd_addr_b),
        .o_tw_addr   (o_tw_addr),
        .o_wr_en     (o_wr_en),
        .o_wr_addr_a (o_wr_addr_a),
        .o_wr_addr_b (o_wr_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},  32'(o_busy),  32'd0);
        chk({tag, ".done"},  32'(o_done),  32'd0);
        chk({tag, ".stage"}, 32'(o_stage), 32'd0);
        chk({tag, ".rd_en"}, 32'(o_rd_en), 32'd0);
        chk({tag, ".rd_a"},  32'(o_rd_addr_a), 32'd0);
        chk({tag, ".rd_b"},  32'(o_rd_addr_b), 32'd0);
        chk({tag, ".tw"},    32'(o_tw_addr), 32'd0);
        chk({tag, ".wr_en"}, 32'(o_wr_en), 32'd0);
        chk({tag, ".wr_a"},  32'(o_wr_addr_a), 32'd0);
        chk({tag, ".wr_b"},  32'(o_wr_addr_b), 32'd0);
    endtask

    // Expected cycles 1..23 after the start edge: 3 stages of 4 reads + 3 drain cycles, done at 22, idle at 23.
    task automatic push_run();
        exp_t tr [0:23];
        int   c;
        for (int i = 0; i <= 23; i++) tr[i] = '0;
        for (int st = 0; st < 3; st++) begin
            for (int j = 1; j <= 7; j++) begin
                c = st * 7 + j;
                tr[c].busy  = 1'b1;
                tr[c].stage = 4'(st);
            end
            for (int k = 0; k < 4; k++) begin
                c = st * 7 + 1 + k;
                tr[c].rd_en = 1'b1;
                tr[c].ra    = 3'(pa_tab[st][k]);
                tr[c].rb    = 3'(pb_tab[st][k]);
                tr[c].tw    = 2'(tw_tab[st][k]);
            end
        end
        tr[22].done  = 1'b1;
        tr[22].stage = 4'd2;
        for (int i = 4; i <= 23; i++) begin
            if (tr[i-3].rd_en) begin
                tr[i].wr_en = 1'b1;
                tr[i].wa    = tr[i-3].ra;
                tr[i].wb    = tr[i-3].rb;
            end
        end
        for (int i = 1; i <= 23; i++) exp_q.push_back(tr[i]);
    endtask

    task automatic pop_check(input int c);
        exp_t e;
        string t;
        t = $sformatf("cyc%0d", c);
        if (exp_q.size() == 0) begin
            chk({t, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({t, ".busy"},  32'(o_busy),  32'(e.busy));
            chk({t, ".done"},  32'(o_done),  32'(e.done));
            chk({t, ".rd_en"}, 32'(o_rd_en), 32'(e.rd_en));
            chk({t, ".wr_en"}, 32'(o_wr_en), 32'(e.wr_en));
            if (e.busy || e.done) chk({t, ".stage"}, 32'(o_stage), 32'(e.stage));
            if (e.rd_en) begin
                chk({t, ".rd_a"}, 32'(o_rd_addr_a), 32'(e.ra));
                chk({t, ".rd_b"}, 32'(o_rd_addr_b), 32'(e.rb));
                chk({t, ".tw"},   32'(o_tw_addr),   32'(e.tw));
            end
            if (e.wr_en) begin
                chk({t, ".wr_a"}, 32'(o_wr_addr_a), 32'(e.wa));
                chk({t, ".wr_b"}, 32'(o_wr_addr_b), 32'(e.wb));
            end
        end
    endtask

    // Called just after a negedge: the start is sampled on the next rising edge (cycle 0).
    task automatic run_full(input int inject_at);
        i_start = 1'b1;
        push_run();
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            i_start = (c == inject_at - 1) ? 1'b1 : 1'b0;
            pop_check(c);
        end
        i_start = 1'b0;
    endtask

    initial begin
        int wr_cnt;
        rst     = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        // Start held across the first edge after reset release must be ignored.
        rst     = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        chk("start_at_release.busy",  32'(o_busy),  32'd0);
        chk("start_at_release.rd_en", 32'(o_rd_en), 32'd0);

        run_full(0);

        // Second start during the run is ignored; the run still finishes at cycle 22.
        run_full(5);

        // Reset during stage 1, k=2, then restart cleanly.
        i_start = 1'b1;
        push_run();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            pop_check(c);
        end
        rst = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post_reset%0d.wr_en", c), 32'(o_wr_en), 32'd0);
            chk($sformatf("post_reset%0d.rd_en", c), 32'(o_rd_en), 32'd0);
        end
        run_full(0);

`ifdef FFT_ABORT_EN
        // Abort while k=1 is on the read port: two writes drain, no done.
        i_start = 1'b1;
        wr_cnt  = 0;
        @(negedge clk);
        i_start = 1'b0;
        chk("abort.c1.rd_a", 32'(o_rd_addr_a), 32'd0);
        @(negedge clk);
        chk("abort.c2.rd_a", 32'(o_rd_addr_a), 32'd2);
        chk("abort.c2.rd_b", 32'(o_rd_addr_b), 32'd3);
        i_abort = 1'b1;
        for (int c = 3; c <= 9; c++) begin
            @(negedge clk);
            i_abort = 1'b0;
            chk($sformatf("abort.c%0d.rd_en", c), 32'(o_rd_en), 32'd0);
            chk($sformatf("abort.c%0d.done", c),  32'(o_done),  32'd0);
            chk($sformatf("abort.c%0d.busy", c),  32'(o_busy),  (c <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("abort.c%0d.wr_en", c), 32'(o_wr_en), (c == 4 || c == 5) ? 32'd1 : 32'd0);
            if (o_wr_en) wr_cnt++;
            if (c == 4) begin
                chk("abort.c4.wr_a", 32'(o_wr_addr_a), 32'd0);
                chk("abort.c4.wr_b", 32'(o_wr_addr_b), 32'd1);
            end
            if (c == 5) begin
                chk("abort.c5.wr_a", 32'(o_wr_addr_a), 32'd2);
                chk("abort.c5.wr_b", 32'(o_wr_addr_b), 32'd3);
            end
        end
        chk("abort.write_count", 32'(wr_cnt), 32'd2);
`else
        wr_cnt = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
